ip_fetch_ctrl: RTL and testbench
================================

// Module: ip_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the 8-bit instruction-pointer register (IP). Drives the IP register's EN/SEL/D controls.
//  Issues one instruction-memory read per IP value and presents the fetched word to the decoder (valid/ready).
//  Redirects the IP on jumps from execute. Sits between the IP register, instruction memory and decode stage.
// PARAMETERS
//  AW         8      address width; equals IP register width
//  IW         16     instruction word width
//  IRQ_VECTOR 8'hF0  interrupt entry address (used only with FETCH_IRQ_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   level; leave IDLE and begin fetching
//  halt         in   1   level; stop at next instruction boundary
//  ip_q         in   AW  current IP register value
//  ip_en        out  1   IP register write enable
//  ip_sel       out  1   IP mux select: 0 = IP+1, 1 = load ip_d
//  ip_d         out  AW  IP load value
//  mem_req      out  1   instruction read request
//  mem_addr     out  AW  read address (= ip_q while mem_req)
//  mem_ack      in   1   read done; mem_rdata valid this cycle
//  mem_rdata    in   IW  read data
//  instr_valid  out  1   instr_data/instr_addr valid to decoder
//  instr_data   out  IW  fetched word
//  instr_addr   out  AW  address of fetched word
//  instr_ready  in   1   decoder accepts
//  jmp_valid    in   1   1-cycle pulse: redirect IP to jmp_target
//  jmp_target   in   AW  jump destination
//  irq / iret   in   1   (FETCH_IRQ_EN only) interrupt request level / return pulse
//  irq_ack      out  1   (FETCH_IRQ_EN only) 1-cycle pulse on interrupt entry
//  ret_ip       out  AW  (FETCH_IRQ_EN only) saved return address
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; jmp_pend=0, instr buffer=0. Mid-operation reset abandons any in-flight mem_req.
//  FSM: IDLE -> FETCH when start & ~halt. FETCH: mem_req=1, mem_addr=ip_q, held until mem_ack.
//   On mem_ack with no jump pending: capture mem_rdata/ip_q into the buffer; go to ISSUE.
//   ISSUE: instr_valid=1. On instr_valid&instr_ready: ip_en=1, ip_sel=0 (IP+1); next state is IDLE if halt, else FETCH.
//  Throughput: zero-wait memory (mem_ack in the request cycle) gives 1 instr / 2 cycles. IP updates at the handshake edge.
//   The next FETCH therefore sees the new ip_q.
//  Wrap: IP 8'hFF + 1 = 8'h00; no flag, fetching continues.
//  Jumps (priority over everything):
//   IDLE:  ip_en=1, ip_sel=1, ip_d=jmp_target same cycle; stay IDLE.
//   FETCH: the request cannot be aborted; set jmp_pend and latch the target (a newer pulse overwrites it).
//    On mem_ack (pending, or jmp_valid in that cycle): discard data, load IP with target, clear jmp_pend, stay FETCH.
//   ISSUE: instr_valid = ISSUE & ~jmp_valid, so no transfer occurs even if instr_ready=1.
//    Buffered word is squashed; IP loads target; go FETCH (IDLE if halt).
//  halt is sampled only at an instruction boundary (ISSUE handshake or jump in ISSUE); never drops mem_req mid-request.
// CONFIGURATION
//  FETCH_IRQ_EN defined: irq sampled at the ISSUE handshake when ~in_isr & ~jmp_valid.
//   Action: ret_ip <= ip_q+1, ip_d=IRQ_VECTOR, ip_sel=1, irq_ack=1 for 1 cycle, in_isr=1.
//   iret pulse (any state, below jmp_valid): load IP from ret_ip, in_isr=0. irq ignored while in_isr.
//  FETCH_IRQ_EN undefined: ports irq/iret/irq_ack/ret_ip and in_isr absent; IRQ_VECTOR unused.
// STRUCTURE
//  Shared package fetch_pkg: state encodings (IDLE=2'b00, FETCH=2'b01, ISSUE=2'b10), IP_SEL_INC=1'b0,
//   IP_SEL_LOAD=1'b1, default AW/IW.
//  Flat module; no sub-module. The IP register is instantiated beside this block by the parent, not inside it.
// TESTING
//  1 Reset, ip_q=8'h10, start=1, mem_ack same cycle -> mem_addr=8'h10; instr_valid next cycle; ip_en/ip_sel=0 on ready.
//  2 mem_ack delayed 3 cycles -> mem_req held 4 cycles with stable mem_addr; exactly one ISSUE per address.
//  3 jmp_valid (target 8'h40) during FETCH at 8'h12 -> data at 8'h12 never issued; next mem_addr=8'h40.
//  4 jmp_valid with instr_ready in ISSUE -> instr_valid=0 that cycle; IP loads 8'h40; no decoder transfer.
//  5 ip_q=8'hFF, accept -> next mem_addr=8'h00; halt high at handshake -> IDLE, mem_req=0.
//  6 (FETCH_IRQ_EN) irq at handshake with ip_q=8'h22 -> irq_ack 1 cycle, ret_ip=8'h23, fetch 8'hF0; iret -> fetch 8'h23.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encodings,
// IP mux select codes and default address/instruction widths.
package fetch_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_IW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10
  } fetch_state_t;

  localparam logic IP_SEL_INC  = 1'b0;
  localparam logic IP_SEL_LOAD = 1'b1;

endpackage

// File: rtl/ip_fetch_ctrl.sv
// Fetch sequencer for the instruction-pointer register. Issues one memory
// read per IP value, hands the word to decode over valid/ready, and redirects
// the IP on jumps. The IP register itself lives in the parent.
// Optional interrupt entry/return support is enabled with FETCH_IRQ_EN.
module ip_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int IW = DEFAULT_IW
`ifdef FETCH_IRQ_EN
  ,
  parameter logic [AW-1:0] IRQ_VECTOR = AW'(8'hF0)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic [AW-1:0] ip_q,
  output logic          ip_en,
  output logic          ip_sel,
  output logic [AW-1:0] ip_d,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic          instr_valid,
  output logic [IW-1:0] instr_data,
  output logic [AW-1:0] instr_addr,
  input  logic          instr_ready,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_target
`ifdef FETCH_IRQ_EN
  ,
  input  logic          irq,
  input  logic          iret,
  output logic          irq_ack,
  output logic [AW-1:0] ret_ip
`endif
);

  fetch_state_t  state_q, state_d;
  logic          jmp_pend_q, jmp_pend_d;
  logic [AW-1:0] jmp_tgt_q, jmp_tgt_d;
  logic [IW-1:0] buf_data_q;
  logic [AW-1:0] buf_addr_q;
  logic          capture;
  logic          redir_now;
  logic [AW-1:0] redir_tgt;
  logic [AW-1:0] pend_tgt;

`ifdef FETCH_IRQ_EN
  logic          in_isr_q;
  logic          irq_ack_q;
  logic [AW-1:0] ret_ip_q;
  logic          take_irq;
  logic          iret_taken;
`endif

  // Merge every source of IP redirection into one request; jumps outrank iret
  always_comb begin
    redir_now = jmp_valid;
    redir_tgt = jmp_target;
`ifdef FETCH_IRQ_EN
    iret_taken = 1'b0;
    if (!jmp_valid && iret) begin
      redir_now  = 1'b1;
      redir_tgt  = ret_ip_q;
      iret_taken = 1'b1;
    end
`endif
    pend_tgt = redir_now ? redir_tgt : jmp_tgt_q;
  end

  // Next-state and IP register control; the IP controls must act in the same cycle
  always_comb begin
    state_d    = state_q;
    jmp_pend_d = jmp_pend_q;
    jmp_tgt_d  = jmp_tgt_q;
    capture    = 1'b0;
    ip_en      = 1'b0;
    ip_sel     = IP_SEL_INC;
    ip_d       = '0;
`ifdef FETCH_IRQ_EN
    take_irq   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (redir_now) begin
          ip_en  = 1'b1;
          ip_sel = IP_SEL_LOAD;
          ip_d   = redir_tgt;
        end else if (start && !halt) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          if (redir_now || jmp_pend_q) begin
            ip_en      = 1'b1;
            ip_sel     = IP_SEL_LOAD;
            ip_d       = pend_tgt;
            jmp_pend_d = 1'b0;
          end else begin
            capture = 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (redir_now) begin
          jmp_pend_d = 1'b1;
          jmp_tgt_d  = redir_tgt;
        end
      end
      ST_ISSUE: begin
        if (redir_now) begin
          ip_en   = 1'b1;
          ip_sel  = IP_SEL_LOAD;
          ip_d    = redir_tgt;
          state_d = halt ? ST_IDLE : ST_FETCH;
        end else if (instr_ready) begin
          ip_en   = 1'b1;
          ip_sel  = IP_SEL_INC;
`ifdef FETCH_IRQ_EN
          if (irq && !in_isr_q) begin
            ip_sel   = IP_SEL_LOAD;
            ip_d     = IRQ_VECTOR;
            take_irq = 1'b1;
          end
`endif
          state_d = halt ? ST_IDLE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, pending jump and the one-entry instruction buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      jmp_pend_q <= 1'b0;
      jmp_tgt_q  <= '0;
      buf_data_q <= '0;
      buf_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      jmp_pend_q <= jmp_pend_d;
      jmp_tgt_q  <= jmp_tgt_d;
      if (capture) begin
        buf_data_q <= mem_rdata;
        buf_addr_q <= ip_q;
      end
    end
  end

`ifdef FETCH_IRQ_EN
  // Interrupt bookkeeping: return address, in-service flag and entry pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_isr_q  <= 1'b0;
      irq_ack_q <= 1'b0;
      ret_ip_q  <= '0;
    end else begin
      irq_ack_q <= take_irq;
      if (take_irq) begin
        in_isr_q <= 1'b1;
        ret_ip_q <= ip_q + AW'(1);
      end else if (iret_taken) begin
        in_isr_q <= 1'b0;
      end
    end
  end

  assign irq_ack = irq_ack_q;
  assign ret_ip  = ret_ip_q;
`endif

  assign mem_req     = (state_q == ST_FETCH);
  assign mem_addr    = mem_req ? ip_q : '0;
  assign instr_valid = (state_q == ST_ISSUE) && !redir_now;
  assign instr_data  = buf_data_q;
  assign instr_addr  = buf_addr_q;

endmodule

// File: tb/tb_ip_fetch_ctrl.sv
// Self-checking bench for ip_fetch_ctrl (default build, FETCH_IRQ_EN undefined).
// Models the external IP register and a memory with programmable ack latency.
// A per-cycle checker tracks the address stream the decoder must see, while
// directed steps pin literal values for reset, latency, jumps, wrap and halt.
module tb_ip_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic [7:0]  ip_q;
  logic        ip_en;
  logic        ip_sel;
  logic [7:0]  ip_d;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [7:0]  instr_addr;
  logic        instr_ready;
  logic        jmp_valid;
  logic [7:0]  jmp_target;

  logic        preset_req;
  logic [7:0]  preset_val;
  int          ack_delay;
  int          wait_cnt;
  int          checks;
  int          errors;
  logic [7:0]  exp_addr;

  ip_fetch_ctrl #(.AW(8), .IW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .ip_q        (ip_q),
    .ip_en       (ip_en),
    .ip_sel      (ip_sel),
    .ip_d        (ip_d),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr),
    .instr_ready (instr_ready),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External IP register: load, increment with 8-bit wrap, or bench preset
  always @(posedge clk or posedge rst) begin
    if (rst)             ip_q <= 8'h00;
    else if (preset_req) ip_q <= preset_val;
    else if (ip_en)      ip_q <= ip_sel ? ip_d : ip_q + 8'd1;
  end

  // Memory: word content is {addr, ~addr}; ack after ack_delay waiting cycles
  always @(posedge clk or posedge rst) begin
    if (rst)                     wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = {mem_addr, ~mem_addr};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic hl, input logic rdy,
                               input logic jv, input logic [7:0] jt);
    start       = st;
    halt        = hl;
    instr_ready = rdy;
    jmp_valid   = jv;
    jmp_target  = jt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  // Per-cycle checker: the decoder must see a gap-free IP walk that restarts at each jump target
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("mem_addr_rule", {24'd0, mem_addr}, {24'd0, (mem_req ? ip_q : 8'h00)});
      if (instr_valid)
        checkOutput("instr_data_rule", {16'd0, instr_data}, {16'd0, instr_addr, ~instr_addr});
      if (jmp_valid)
        checkOutput("no_valid_on_jump", {31'd0, instr_valid}, 32'd0);
      if (ip_en && ip_sel == 1'b0)
        checkOutput("inc_only_on_handshake", {31'd0, (instr_valid && instr_ready)}, 32'd1);
      if (preset_req) begin
        exp_addr = preset_val;
      end else if (instr_valid && instr_ready) begin
        checkOutput("stream_addr", {24'd0, instr_addr}, {24'd0, exp_addr});
        checkOutput("handshake_ip_en", {31'd0, ip_en}, 32'd1);
        exp_addr = instr_addr + 8'd1;
      end else if (jmp_valid) begin
        exp_addr = jmp_target;
      end
    end
  end

  initial begin
    int  n;
    bit  got;
    checks     = 0;
    errors     = 0;
    exp_addr   = 8'h00;
    rst        = 1'b1;
    preset_req = 1'b0;
    preset_val = 8'h00;
    ack_delay  = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(); tick();
    peek();
    checkOutput("rst_mem_req",     {31'd0, mem_req},     32'd0);
    checkOutput("rst_mem_addr",    {24'd0, mem_addr},    32'd0);
    checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr_data",  {16'd0, instr_data},  32'd0);
    checkOutput("rst_ip_en",       {31'd0, ip_en},       32'd0);

    // Zero-wait fetch from 8'h10
    tick(); rst = 1'b0; preset_req = 1'b1; preset_val = 8'h10;
    tick(); preset_req = 1'b0; applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    peek(); checkOutput("idle_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    peek(); checkOutput("t1_mem_req",  {31'd0, mem_req},  32'd1);
            checkOutput("t1_mem_addr", {24'd0, mem_addr}, 32'h10);
    tick();
    peek(); checkOutput("t1_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("t1_addr",  {24'd0, instr_addr},  32'h10);
            checkOutput("t1_data",  {16'd0, instr_data},  32'h10EF);
            checkOutput("t1_no_en", {31'd0, ip_en},       32'd0);
    tick(); instr_ready = 1'b1; ack_delay = 3;
    peek(); checkOutput("t1_ip_en",  {31'd0, ip_en},  32'd1);
            checkOutput("t1_ip_sel", {31'd0, ip_sel}, 32'd0);

    // Three-cycle memory latency at 8'h11
    tick(); instr_ready = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      peek();
      if (mem_req) begin
        n++;
        checkOutput("t2_addr_stable", {24'd0, mem_addr}, 32'h11);
      end
      if (mem_ack) begin got = 1'b1; break; end
      tick();
    end
    checkOutput("t2_ack_seen", {31'd0, got}, 32'd1);
    checkOutput("t2_req_cycles", n, 32'd4);
    tick();
    peek(); checkOutput("t2_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("t2_addr",  {24'd0, instr_addr},  32'h11);
    tick(); instr_ready = 1'b1;
    peek();

    // Jump to 8'h40 while fetching 8'h12
    tick(); instr_ready = 1'b0;
    peek(); checkOutput("t3_fetch_12", {24'd0, mem_addr}, 32'h12);
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h40);
    peek(); checkOutput("t3_no_abort", {31'd0, mem_req}, 32'd1);
            checkOutput("t3_defer_en", {31'd0, ip_en},   32'd0);
    tick(); jmp_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      peek();
      if (mem_ack) begin got = 1'b1; break; end
      tick();
    end
    checkOutput("t3_ack_seen", {31'd0, got},    32'd1);
    checkOutput("t3_ip_en",    {31'd0, ip_en},  32'd1);
    checkOutput("t3_ip_sel",   {31'd0, ip_sel}, 32'd1);
    checkOutput("t3_ip_d",     {24'd0, ip_d},   32'h40);
    checkOutput("t3_squash",   {31'd0, instr_valid}, 32'd0);
    tick(); ack_delay = 0;
    peek(); checkOutput("t3_fetch_40", {24'd0, mem_addr}, 32'h40);
    tick();
    peek(); checkOutput("t3_issue_40", {24'd0, instr_addr}, 32'h40);

    // Jump in ISSUE with ready high: no transfer, IP loads 8'h40
    tick(); applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h40);
    peek(); checkOutput("t4_valid_low", {31'd0, instr_valid}, 32'd0);
            checkOutput("t4_ip_en",     {31'd0, ip_en},       32'd1);
            checkOutput("t4_ip_sel",    {31'd0, ip_sel},      32'd1);
            checkOutput("t4_ip_d",      {24'd0, ip_d},        32'h40);
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    peek(); checkOutput("t4_refetch", {24'd0, mem_addr}, 32'h40);
    tick();
    peek();

    // Wrap from 8'hFF to 8'h00, then halt at the handshake
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick(); jmp_valid = 1'b0;
    peek(); checkOutput("t5_fetch_ff", {24'd0, mem_addr}, 32'hFF);
    tick();
    peek(); checkOutput("t5_data_ff", {16'd0, instr_data}, 32'hFF00);
    tick(); instr_ready = 1'b1;
    peek();
    tick(); instr_ready = 1'b0;
    peek(); checkOutput("t5_wrap_addr", {24'd0, mem_addr}, 32'h00);
            checkOutput("t5_wrap_req",  {31'd0, mem_req},  32'd1);
    tick();
    peek(); checkOutput("t5_issue_00", {24'd0, instr_addr}, 32'h00);
    tick(); instr_ready = 1'b1; halt = 1'b1;
    peek(); checkOutput("t5_halt_hs", {31'd0, ip_en}, 32'd1);
    tick(); instr_ready = 1'b0;
    peek(); checkOutput("t5_idle_req",   {31'd0, mem_req},     32'd0);
            checkOutput("t5_idle_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    peek(); checkOutput("t5_stay_idle", {31'd0, mem_req}, 32'd0);

    // Jump while IDLE loads the IP immediately and stays idle
    tick(); applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h80);
    peek(); checkOutput("idle_jmp_en",  {31'd0, ip_en},   32'd1);
            checkOutput("idle_jmp_sel", {31'd0, ip_sel},  32'd1);
            checkOutput("idle_jmp_d",   {24'd0, ip_d},    32'h80);
            checkOutput("idle_jmp_req", {31'd0, mem_req}, 32'd0);
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    peek(); checkOutput("idle_jmp_stay", {31'd0, mem_req}, 32'd0);
    tick();
    peek(); checkOutput("resume_80", {24'd0, mem_addr}, 32'h80);

    // Mid-operation reset clears everything
    tick(); rst = 1'b1;
    peek(); checkOutput("mid_rst_req",   {31'd0, mem_req},     32'd0);
            checkOutput("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
            checkOutput("mid_rst_data",  {16'd0, instr_data},  32'd0);
    tick(); rst = 1'b0; start = 1'b0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
